fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
Instruction-fetch stage sitting directly upstream of the decode/register-read stage of the LEGv8 core. It replaces the combinational instruction-memory lookup with a pipelined fetch. It issues sequential PC requests to an instruction memory that has variable response latency and buffers returned instructions with their PCs in a small queue. It hands them to decode over a valid/ready handshake. Taken branches from the execute stage redirect fetch, flush the queue, and discard in-flight responses.

Parameters:
ADDR_W, 64, PC / memory address width
INSTR_W, 32, instruction width
DEPTH, 4, queue entries; also the cap on (queued + outstanding) requests; power of two, >= 2

Ports:
CLK  in  1  clock, all state updates on posedge
reset  in  1  synchronous, active-high reset
startpc  in  ADDR_W  PC loaded while reset is high
redirect_valid  in  1  taken branch / unconditional branch this cycle
redirect_pc  in  ADDR_W  branch target
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_resp_valid  in  1  in-order response valid (always accepted)
imem_resp_data  in  INSTR_W  returned instruction
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode consumes instruction
inst_data  out  INSTR_W  head-of-queue instruction
inst_pc  out  ADDR_W  PC of head instruction

Behaviour:
- Reset (sync, high): fetch_pc<=startpc; queue empty; outstanding<=0; drop_cnt<=0. imem_req_valid=0 and inst_valid=0 while reset is high.
- credit = (count + outstanding) < DEPTH.
- imem_req_valid = !reset && credit && !redirect_valid; imem_req_addr = fetch_pc. Both are combinational from registered state.
- Request accept (req_valid && req_ready): fetch_pc<=fetch_pc+4, wrapping mod 2^ADDR_W; outstanding+1.
- Response: outstanding-1.
  - drop_cnt>0: discard the response and decrement drop_cnt.
  - Otherwise push {PC, data}. Tag PC comes from a resp_pc register: set on redirect/reset, +4 per kept response.
- Responses return strictly in request order, and the memory never returns more than were requested.
- inst_valid = queue non-empty; inst_data/inst_pc = head entry. Pop on inst_valid && inst_ready.
- Push and pop in the same cycle: count unchanged, data passes in order. Push into a full queue is impossible by credit; the bench asserts this.
- Minimum latency: a response at cycle N is visible on inst_* at N+1 (registered queue, no bypass).
- Redirect (priority over everything in that cycle):
  - fetch_pc<=resp_pc<={redirect_pc[ADDR_W-1:2],2'b00}.
  - Queue flushed; any same-cycle pop still counts as consumed.
  - drop_cnt <= outstanding (post-update, counting a same-cycle response) minus any response already dropped/pushed that cycle. Equivalently, every request issued before the redirect is discarded.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop_cnt is recomputed each time.
- reset overrides redirect. Reset mid-flight also sets drop_cnt<=outstanding: the memory still returns in-flight responses, and they must be discarded. outstanding is not cleared in that case, only the queue and PCs.
- Counter widths: count, outstanding, and drop_cnt are clog2(DEPTH)+1 bits; all stay <= DEPTH.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_BYTES=4 and the PC-alignment mask.
  - Typedef fetch_entry_t {pc[ADDR_W], instr[INSTR_W]}.
- One sub-module, fetch_queue: synchronous FIFO of fetch_entry_t, DEPTH entries, with push/pop/flush, count output, and flush priority over push.

Test Plan:
- Reset, startpc=0x100, memory latency 1, inst_ready=1 -> requests at 0x100,0x104,0x108...; first inst_valid with inst_pc=0x100 two cycles after the first accept; PCs strictly +4.
- inst_ready=0, latency 2 -> exactly 4 requests issued, then imem_req_valid=0; queue holds 0x100..0x10C. Assert inst_ready -> issue resumes one request per pop.
- Redirect to 0x2003 with 3 requests in flight -> fetch restarts at 0x2000; 3 stale responses dropped; next inst_pc=0x2000; no stale PC ever appears on inst_pc.
- Redirect in the same cycle as a pop and a response -> popped entry consumed once, the response is discarded, and the queue is empty the next cycle.
- fetch_pc=0xFFFF_FFFF_FFFF_FFFC -> next request address 0x0 (wrap).
- Reset asserted with 2 outstanding, startpc=0x400 -> the 2 late responses are discarded; first delivered instruction has inst_pc=0x400.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the pipelined instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned PKG_ADDR_W  = 64;
    localparam int unsigned PKG_INSTR_W = 32;

    // Bytes per instruction; the PC advances by this much per fetch.
    localparam int unsigned INSTR_BYTES = 4;

    // Clears the byte-offset bits of a PC so that fetch stays word aligned.
    localparam logic [PKG_ADDR_W-1:0] PC_ALIGN_MASK = ~(PKG_ADDR_W'(INSTR_BYTES - 1));

    // One buffered fetch result: the instruction and the PC it was fetched from.
    typedef struct packed {
        logic [PKG_ADDR_W-1:0]  pc;
        logic [PKG_INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PKG_ADDR_W-1:0] align_pc(input logic [PKG_ADDR_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries. Flush wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_entry,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    // The parent's credit scheme keeps push away from a full queue; the guard
    // only protects storage if that ever breaks.
    assign do_push = push && !flush && !full;
    assign do_pop  = pop && !flush && !empty;

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
    end

    // Entry storage; no reset needed since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Pipelined instruction fetch: issues sequential PC requests to a variable-latency
// memory, buffers in-order responses with their PCs, and feeds decode over
// valid/ready. Redirects and resets restart fetch and discard in-flight responses.
// ADDR_W and INSTR_W must match the widths of fetch_entry_t in fetch_pkg.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W  = PKG_ADDR_W,
    parameter int unsigned INSTR_W = PKG_INSTR_W,
    parameter int unsigned DEPTH   = 4
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  startpc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [ADDR_W-1:0]  inst_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic              q_push;
    logic              q_pop;
    logic              q_flush;
    fetch_entry_t      q_push_entry;
    fetch_entry_t      q_head;

    logic [CNT_W:0]    inflight;
    logic              credit;
    logic              req_fire;
    logic              resp_drop;
    logic              resp_keep;
    logic              restart;
    logic [ADDR_W-1:0] restart_pc;

    // Queued plus outstanding requests may never exceed DEPTH, so every
    // response is guaranteed a free queue slot.
    assign inflight = {1'b0, q_count} + {1'b0, outstanding_q};
    assign credit   = (inflight < (CNT_W + 1)'(DEPTH));

    assign imem_req_valid = !reset && credit && !redirect_valid;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
    assign resp_keep = imem_resp_valid && (drop_cnt_q == '0);

    // Reset and redirect share the restart path; reset takes priority.
    assign restart    = reset || redirect_valid;
    assign restart_pc = reset ? startpc : align_pc(redirect_pc);

    // Counter and PC next-state.
    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire) begin
            outstanding_d = outstanding_d + CNT_W'(1);
        end
        if (imem_resp_valid) begin
            outstanding_d = outstanding_d - CNT_W'(1);
        end

        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        drop_cnt_d = drop_cnt_q;
        if (restart) begin
            // Every request still in flight after this cycle predates the
            // restart and must be discarded when it returns. Outstanding keeps
            // counting through reset because the memory still answers them.
            fetch_pc_d = restart_pc;
            resp_pc_d  = restart_pc;
            drop_cnt_d = outstanding_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(INSTR_BYTES);
            end
            if (resp_keep) begin
                resp_pc_d = resp_pc_q + ADDR_W'(INSTR_BYTES);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
        end
    end

    // Fetch state registers; synchronous reset is folded into the restart path.
    always_ff @(posedge CLK) begin
        fetch_pc_q    <= fetch_pc_d;
        resp_pc_q     <= resp_pc_d;
        outstanding_q <= outstanding_d;
        drop_cnt_q    <= drop_cnt_d;
    end

    assign q_push             = resp_keep && !restart;
    assign q_flush            = restart;
    assign q_pop              = inst_valid && inst_ready;
    assign q_push_entry.pc    = resp_pc_q;
    assign q_push_entry.instr = imem_resp_data;

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk        (CLK),
        .flush      (q_flush),
        .push       (q_push),
        .push_entry (q_push_entry),
        .pop        (q_pop),
        .head       (q_head),
        .count      (q_count),
        .empty      (q_empty)
    );

    assign inst_valid = !reset && !q_empty;
    assign inst_data  = q_head.instr;
    assign inst_pc    = q_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model.
module tb_fetch_unit;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned DEPTH   = 4;

    logic               CLK = 1'b0;
    logic               reset;
    logic [ADDR_W-1:0]  startpc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;

    always #5 CLK = ~CLK;

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .startpc         (startpc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_data       (inst_data),
        .inst_pc         (inst_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Memory model state: pending responses in request order.
    logic [ADDR_W-1:0] pend_addr[$];
    int                pend_due[$];
    int                lat;
    int                cyc;
    int                last_due;

    logic [ADDR_W-1:0] req_log[$];
    logic [ADDR_W-1:0] pc_log[$];
    int                data_bad;
    int                push_full_viol;
    int                first_acc;
    int                first_val;
    logic              last_req_valid;
    logic              last_pop_fire;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [INSTR_W-1:0] mem_data(input logic [ADDR_W-1:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [ADDR_W-1:0] req_at(input int i);
        return (i < req_log.size()) ? req_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic logic [ADDR_W-1:0] pc_at(input int i);
        return (i < pc_log.size()) ? pc_log[i] : 64'hDEAD_DEAD_DEAD_DEAD;
    endfunction

    function automatic int count_below(input logic [ADDR_W-1:0] lim);
        int n = 0;
        for (int i = 0; i < pc_log.size(); i++) begin
            if (pc_log[i] < lim) n++;
        end
        return n;
    endfunction

    function automatic int seq_breaks();
        int n = 0;
        for (int i = 1; i < pc_log.size(); i++) begin
            if (pc_log[i] != pc_log[i-1] + 64'd4) n++;
        end
        return n;
    endfunction

    // One clock cycle: drive the memory response, sample at mid-cycle, update the
    // model after the edge, and return 1 time unit after the edge.
    task automatic cycle();
        logic              fire;
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] ppc;
        logic [INSTR_W-1:0] pdata;
        int                due;
        @(negedge CLK);
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_data(pend_addr[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        last_req_valid = imem_req_valid;
        fire           = imem_req_valid && imem_req_ready;
        addr           = imem_req_addr;
        last_pop_fire  = inst_valid && inst_ready;
        ppc            = inst_pc;
        pdata          = inst_data;
        if (inst_valid && first_val < 0) first_val = cyc;
        if (dut.q_push && dut.q_count == 3'd4) push_full_viol++;
        @(posedge CLK);
        if (imem_resp_valid) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (fire) begin
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_addr.push_back(addr);
            pend_due.push_back(due);
            req_log.push_back(addr);
            if (first_acc < 0) first_acc = cyc;
        end
        if (last_pop_fire) begin
            pc_log.push_back(ppc);
            if (pdata !== mem_data(ppc)) data_bad++;
        end
        cyc++;
        #1;
    endtask

    // Long enough reset that every earlier request has returned and been dropped.
    task automatic do_reset(input logic [ADDR_W-1:0] pc, input int n);
        reset   = 1'b1;
        startpc = pc;
        repeat (n) cycle();
        reset = 1'b0;
        req_log.delete();
        pc_log.delete();
        first_acc = -1;
        first_val = -1;
    endtask

    initial begin
        reset           = 1'b1;
        startpc         = 64'h100;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        inst_ready      = 1'b1;
        lat             = 1;
        cyc             = 0;
        last_due        = -1;
        data_bad        = 0;
        push_full_viol  = 0;
        first_acc       = -1;
        first_val       = -1;

        // Reset outputs and sequential fetch, latency 1.
        cycle();
        check_eq("rst_req_valid", 64'(last_req_valid), 64'd0);
        check_eq("rst_inst_valid", 64'(inst_valid), 64'd0);
        do_reset(64'h100, 4);
        repeat (10) cycle();
        check_eq("t1_req0", req_at(0), 64'h100);
        check_eq("t1_req1", req_at(1), 64'h104);
        check_eq("t1_req2", req_at(2), 64'h108);
        check_eq("t1_first_latency", 64'(first_val - first_acc), 64'd2);
        check_eq("t1_pc0", pc_at(0), 64'h100);
        check_eq("t1_delivered", 64'(pc_log.size()), 64'd8);
        check_eq("t1_seq", 64'(seq_breaks()), 64'd0);

        // Backpressure: queue fills, issue stops at DEPTH, then resumes per pop.
        lat        = 2;
        inst_ready = 1'b0;
        do_reset(64'h100, 8);
        repeat (10) cycle();
        check_eq("t2_req_count", 64'(req_log.size()), 64'd4);
        check_eq("t2_req3", req_at(3), 64'h10C);
        check_eq("t2_req_valid_off", 64'(imem_req_valid), 64'd0);
        check_eq("t2_head_valid", 64'(inst_valid), 64'd1);
        check_eq("t2_head_pc", inst_pc, 64'h100);
        check_eq("t2_q_count", 64'(dut.q_count), 64'd4);
        inst_ready = 1'b1;
        cycle();
        check_eq("t2_no_req_full", 64'(last_req_valid), 64'd0);
        cycle();
        check_eq("t2_resume_count", 64'(req_log.size()), 64'd5);
        check_eq("t2_resume_addr", req_at(4), 64'h110);
        repeat (10) cycle();
        check_eq("t2_pc0", pc_at(0), 64'h100);
        check_eq("t2_pc3", pc_at(3), 64'h10C);
        check_eq("t2_seq", 64'(seq_breaks()), 64'd0);

        // Redirect with three requests in flight.
        lat = 4;
        do_reset(64'h100, 8);
        repeat (3) cycle();
        check_eq("t3_inflight", 64'(req_log.size()), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h2003;
        cycle();
        redirect_valid = 1'b0;
        check_eq("t3_no_req_redirect", 64'(last_req_valid), 64'd0);
        repeat (16) cycle();
        check_eq("t3_restart_addr", req_at(3), 64'h2000);
        check_eq("t3_pc0", pc_at(0), 64'h2000);
        check_eq("t3_pc1", pc_at(1), 64'h2004);
        check_eq("t3_stale", 64'(count_below(64'h2000)), 64'd0);

        // Redirect coinciding with a pop and a response.
        lat = 1;
        do_reset(64'h100, 8);
        repeat (3) cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000;
        cycle();
        redirect_valid = 1'b0;
        check_eq("t4_pop_in_redirect", 64'(last_pop_fire), 64'd1);
        check_eq("t4_empty_after", 64'(inst_valid), 64'd0);
        repeat (8) cycle();
        check_eq("t4_pc0", pc_at(0), 64'h100);
        check_eq("t4_pc1", pc_at(1), 64'h104);
        check_eq("t4_pc2", pc_at(2), 64'h3000);
        check_eq("t4_pc3", pc_at(3), 64'h3004);

        // PC wrap at the top of the address space.
        do_reset(64'hFFFF_FFFF_FFFF_FFF8, 8);
        repeat (8) cycle();
        check_eq("t5_req1", req_at(1), 64'hFFFF_FFFF_FFFF_FFFC);
        check_eq("t5_req_wrap", req_at(2), 64'h0);
        check_eq("t5_req3", req_at(3), 64'h4);
        check_eq("t5_pc_wrap", pc_at(2), 64'h0);

        // Reset with two requests outstanding.
        lat = 3;
        do_reset(64'h100, 8);
        repeat (2) cycle();
        reset   = 1'b1;
        startpc = 64'h400;
        cycle();
        reset = 1'b0;
        req_log.delete();
        repeat (12) cycle();
        check_eq("t6_req0", req_at(0), 64'h400);
        check_eq("t6_pc0", pc_at(0), 64'h400);
        check_eq("t6_pc1", pc_at(1), 64'h404);
        check_eq("t6_stale", 64'(count_below(64'h400)), 64'd0);

        check_eq("data_match", 64'(data_bad), 64'd0);
        check_eq("no_push_full", 64'(push_full_viol), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
